// File: rtl/iq_pack.sv
// IQ packer: pops one I/Q sample pair from two FWFT FIFOs, quantizes each to
// saturated signed 16 bits and pushes {Q16, I16} into the output FIFO.
module iq_pack #(
  parameter int QUANT_BITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  output logic        i_rd_en,
  input  logic        i_empty,
  input  logic [31:0] i_dout,
  output logic        q_rd_en,
  input  logic        q_empty,
  input  logic [31:0] q_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [31:0] out_din,
  output logic        sat_flag,
  output logic        o_dbg_state
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_hold;
  logic        r_sat;

  logic        w_take;
  logic [16:0] w_i_q;
  logic [16:0] w_q_q;

  // Returns {clamped, value}: floor shift, then clamp to the int16 range.
  function automatic logic [16:0] sat16(input logic [31:0] x);
    logic signed [31:0] s;
    s = $signed(x) >>> QUANT_BITS;
    if (s > 32'sd32767)
      sat16 = {1'b1, 16'h7FFF};
    else if (s < -32'sd32768)
      sat16 = {1'b1, 16'h8000};
    else
      sat16 = {1'b0, s[15:0]};
  endfunction

  assign w_i_q = sat16(i_dout);
  assign w_q_q = sat16(q_dout);

  // Handshake: a pair is taken only when both FIFOs hold data and the holding
  // register is free or being written this cycle; all strobes die in reset.
  assign w_take    = reset && !i_empty && !q_empty
                     && ((r_state == S_LOAD) || !out_full);
  assign i_rd_en   = w_take;
  assign q_rd_en   = w_take;
  assign out_wr_en = reset && (r_state == S_SEND) && !out_full;

  assign out_din     = r_hold;
  assign sat_flag    = r_sat;
  assign o_dbg_state = r_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_LOAD;
      r_hold  <= 32'h0000_0000;
      r_sat   <= 1'b0;
    end else begin
      if (w_take) begin
        r_hold  <= {w_q_q[15:0], w_i_q[15:0]};
        r_sat   <= r_sat | w_i_q[16] | w_q_q[16];
        r_state <= S_SEND;
      end else if ((r_state == S_SEND) && !out_full) begin
        r_state <= S_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_iq_pack.sv
// Bench for iq_pack: queue-based FIFO models, an occupancy/arithmetic reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_iq_pack;

  localparam int QB = 10;

  logic        clock;
  logic        reset;
  logic        i_rd_en, q_rd_en, out_wr_en, sat_flag, o_dbg_state;
  logic        i_empty, q_empty, out_full;
  logic [31:0] i_dout, q_dout, out_din;

  logic [31:0] i_fifo[$];
  logic [31:0] q_fifo[$];
  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];
  logic        m_sat;
  logic        pop_i, pop_q;

  int vectors;
  int miscompares;

  iq_pack #(.QUANT_BITS(QB)) dut (
    .clock(clock), .reset(reset),
    .i_rd_en(i_rd_en), .i_empty(i_empty), .i_dout(i_dout),
    .q_rd_en(q_rd_en), .q_empty(q_empty), .q_dout(q_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .sat_flag(sat_flag), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference quantizer: floor divide by 2^QB, then clamp. Returns {sat, value}.
  function automatic logic [16:0] model_q(input logic [31:0] raw);
    longint v, q;
    v = longint'($signed(raw));
    if (v >= 0) q = v / (64'sd1 << QB);
    else        q = -((-v + (64'sd1 << QB) - 1) / (64'sd1 << QB));
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic refresh();
    i_empty = (i_fifo.size() == 0);
    q_empty = (q_fifo.size() == 0);
    i_dout  = (i_fifo.size() != 0) ? i_fifo[0] : 32'hDEAD_BEEF;
    q_dout  = (q_fifo.size() != 0) ? q_fifo[0] : 32'hDEAD_BEEF;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic push_pair(input logic [31:0] iv, input logic [31:0] qv);
    i_fifo.push_back(iv);
    q_fifo.push_back(qv);
    refresh();
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((i_fifo.size() != 0 || q_fifo.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      step(1);
      n++;
    end
    chk("drain_timeout", {31'd0, (n < max_cycles)}, 32'd1);
  endtask

  // FIFO reaction: pops sampled at the negedge take effect just after the edge.
  always @(posedge clock) begin
    #1;
    if (pop_i && i_fifo.size() != 0) void'(i_fifo.pop_front());
    if (pop_q && q_fifo.size() != 0) void'(q_fifo.pop_front());
    pop_i = 1'b0;
    pop_q = 1'b0;
    refresh();
  end

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clock) begin
    logic        exp_take, exp_wr;
    logic [16:0] mi, mq;
    if (!reset) begin
      exp_q.delete();
      m_sat = 1'b0;
      chk("rst_i_rd_en", {31'd0, i_rd_en}, 32'd0);
      chk("rst_q_rd_en", {31'd0, q_rd_en}, 32'd0);
      chk("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
      chk("rst_out_din", out_din, 32'd0);
      chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
      chk("rst_state", {31'd0, o_dbg_state}, 32'd0);
    end else begin
      exp_take = !i_empty && !q_empty && (exp_q.size() == 0 || !out_full);
      exp_wr   = (exp_q.size() != 0) && !out_full;
      chk("i_rd_en", {31'd0, i_rd_en}, {31'd0, exp_take});
      chk("q_rd_en", {31'd0, q_rd_en}, {31'd0, exp_take});
      chk("out_wr_en", {31'd0, out_wr_en}, {31'd0, exp_wr});
      chk("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
      if (exp_q.size() != 0) chk("out_din", out_din, exp_q[0]);
      if (out_wr_en) wr_log.push_back(out_din);
      if (exp_wr) void'(exp_q.pop_front());
      if (exp_take) begin
        mi = model_q(i_dout);
        mq = model_q(q_dout);
        exp_q.push_back({mq[15:0], mi[15:0]});
        m_sat = m_sat | mi[16] | mq[16];
      end
    end
    pop_i = i_rd_en;
    pop_q = q_rd_en;
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    vectors     = 0;
    miscompares = 0;
    m_sat       = 1'b0;
    pop_i       = 1'b0;
    pop_q       = 1'b0;
    out_full    = 1'b0;
    reset       = 1'b0;
    refresh();
    #22;
    reset = 1'b1;

    // Single pair
    step(1);
    push_pair(32'h0000_0400, 32'hFFFF_F800);
    wait_drain(10);
    step(1);
    chk("single_count", wr_log.size(), 32'd1);
    chk("single_word", wr_log[0], 32'hFFFE_0001);
    chk("single_sat", {31'd0, sat_flag}, 32'd0);

    // Saturation, then floor of -1
    push_pair(32'h7FFF_FFFF, 32'h8000_0000);
    push_pair(32'hFFFF_FFFF, 32'h0000_0000);
    wait_drain(10);
    step(1);
    chk("sat_word", wr_log[1], 32'h8000_7FFF);
    chk("floor_word", wr_log[2], 32'h0000_FFFF);
    chk("sat_sticky", {31'd0, sat_flag}, 32'd1);

    // Streaming 8 pairs
    base = wr_log.size();
    for (int k = 0; k < 8; k++) push_pair(32'(k << QB), 32'(-(k << QB)));
    wait_drain(20);
    step(1);
    chk("stream_count", wr_log.size() - base, 32'd8);
    for (int k = 0; k < 8; k++)
      chk("stream_word", wr_log[base + k], {16'(-k), 16'(k)});

    // Backpressure mid-stream
    base = wr_log.size();
    for (int k = 0; k < 8; k++) push_pair(32'(k << QB), 32'(-(k << QB)));
    step(3);
    out_full = 1'b1;
    step(5);
    out_full = 1'b0;
    wait_drain(20);
    step(1);
    chk("bp_count", wr_log.size() - base, 32'd8);
    for (int k = 0; k < 8; k++)
      chk("bp_word", wr_log[base + k], {16'(-k), 16'(k)});

    // Imbalance: I only, then one Q
    base = wr_log.size();
    for (int k = 1; k <= 3; k++) i_fifo.push_back(32'(k << QB));
    refresh();
    step(10);
    chk("imb_no_write", wr_log.size() - base, 32'd0);
    chk("imb_i_left", i_fifo.size(), 32'd3);
    q_fifo.push_back(32'(7 << QB));
    refresh();
    step(4);
    chk("imb_one_write", wr_log.size() - base, 32'd1);
    chk("imb_word", wr_log[base], 32'h0007_0001);
    chk("imb_i_left2", i_fifo.size(), 32'd2);
    q_fifo.push_back(32'h0);
    q_fifo.push_back(32'h0);
    refresh();
    wait_drain(10);

    // Reset while stalled in S_SEND
    out_full = 1'b1;
    push_pair(32'h0000_2000, 32'h0000_1000);
    step(3);
    base = wr_log.size();
    chk("pre_rst_din", out_din, 32'h0004_0008);
    chk("pre_rst_sat", {31'd0, sat_flag}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_i_rd_en", {31'd0, i_rd_en}, 32'd0);
    chk("async_wr_en", {31'd0, out_wr_en}, 32'd0);
    chk("async_din", out_din, 32'd0);
    chk("async_sat", {31'd0, sat_flag}, 32'd0);
    exp_q.delete();
    m_sat = 1'b0;
    step(2);
    out_full = 1'b0;
    reset = 1'b1;
    step(2);
    chk("post_rst_no_write", wr_log.size() - base, 32'd0);
    push_pair(32'h0000_1400, 32'h0000_0C00);
    wait_drain(10);
    step(1);
    chk("post_rst_count", wr_log.size() - base, 32'd1);
    chk("post_rst_word", wr_log[base], 32'h0003_0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/iq_pack.md
# iq_pack

Transmit-side packer for the IQ sample stream: pops one signed 32-bit I sample and one signed 32-bit Q sample from two FWFT FIFOs, quantizes each to signed 16 bits with saturation, and pushes one packed 32-bit word into an output FIFO. It is the inverse of the IQ split on the receive front end. It sits between the I/Q sample FIFOs and the 32-bit IQ output FIFO.

## Interface
- QUANT_BITS, 10, arithmetic right-shift applied to each 32-bit sample before 16-bit saturation
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- i_rd_en  out  1  pop strobe to the I FIFO
- i_empty  in  1  I FIFO empty
- i_dout  in  32  I sample, signed; FWFT, valid whenever i_empty=0
- q_rd_en  out  1  pop strobe to the Q FIFO
- q_empty  in  1  Q FIFO empty
- q_dout  in  32  Q sample, signed; FWFT, valid whenever q_empty=0
- out_wr_en  out  1  push strobe to the output FIFO
- out_full  in  1  output FIFO full
- out_din  out  32  packed word {Q16, I16}
- sat_flag  out  1  sticky: a sample has saturated since reset

## Operation
- Two states: S_LOAD (holding register empty) and S_SEND (holding register full).
- Pop condition: take = i_empty=0 and q_empty=0 and (state=S_LOAD or out_full=0). When take=1, i_rd_en=q_rd_en=1 in the same cycle; they are never asserted individually.
- On take, register hold = {sat16(q_dout >>> QUANT_BITS), sat16(i_dout >>> QUANT_BITS)}.
  - `>>>` is an arithmetic shift (floor toward −inf).
  - sat16 clamps to [−32768, 32767].
- If either value clamps, set sat_flag=1. sat_flag clears only on reset.
- out_din = hold at all times. out_wr_en = (state=S_SEND) and out_full=0.
- Transitions:
  - S_LOAD: take → S_SEND; otherwise stay in S_LOAD.
  - S_SEND with out_full=1: stay in S_SEND; hold is unchanged; no pops.
  - S_SEND with out_full=0: the word is written. If take=1 in the same cycle, hold reloads and the state stays S_SEND. Otherwise → S_LOAD.
- If only one input FIFO is non-empty, nothing is popped. No partial pair is ever consumed.
- Reset (asynchronous assert, any state):
  - state=S_LOAD, hold=0, sat_flag=0.
  - i_rd_en, q_rd_en and out_wr_en are forced to 0 while reset=0.
  - A pair already popped but not yet written is discarded.

## Timing
- Strobes are combinational from the registered state and the FIFO flags. hold, state and sat_flag are registered.
- Latency: a pair popped in cycle N appears on out_din with out_wr_en=1 in cycle N+1 (if out_full=0).
- Throughput: one word per cycle sustained while both inputs are non-empty and out_full=0.
- Backpressure: when out_full=1 in S_SEND, out_wr_en=0 and no pops occur. On the first cycle with out_full=0, the same word is written.
- Words leave in the same order the pairs were popped. No duplication and no loss.
- Reset outputs: i_rd_en=0, q_rd_en=0, out_wr_en=0, out_din=0x00000000, sat_flag=0.
- First pop can occur in the first rising edge after reset deasserts, given both inputs non-empty.

## Test plan
- Single pair, QUANT_BITS=10: I=0x00000400, Q=0xFFFFF800 → out_din=0xFFFE0001 with one out_wr_en pulse one cycle after the pop; sat_flag=0.
- Saturation and floor:
  - I=0x7FFFFFFF, Q=0x80000000 → 0x80007FFF, and sat_flag=1 from the next cycle.
  - Next pair I=0xFFFFFFFF, Q=0 → 0x0000FFFF; sat_flag stays 1.
- Streaming: preload 8 pairs (I=k<<10, Q=−k<<10, k=0..7), out_full=0 → 8 consecutive out_wr_en cycles; word k = {−k, k} as 16-bit values; both input FIFOs empty at the end.
- Backpressure: hold out_full=1 for 5 cycles during the stream → out_wr_en=0 and no rd_en during the stall; after release the sequence resumes with no gap, loss or repeat.
- Imbalance: I FIFO holds 3 samples and Q stays empty for 10 cycles → no rd_en and no out_wr_en. Push 1 Q sample → exactly one pair is popped and one word is written; I FIFO is left with 2 samples.
- Reset mid-operation: assert reset while in S_SEND with out_full=1 → strobes drop to 0 and out_din=0 asynchronously, and sat_flag=0. After release, the next pair is packed normally and the discarded word is never written.
